// File: rtl/pipeline_hazard_scoreboard.sv
// Operand forwarding and hazard-stall unit for the ID stage. It tracks each in-flight
// register writer across STAGES post-ID slots and selects forwarded operands or raises a stall.
module pipeline_hazard_scoreboard #(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 16,
    parameter int STAGES      = 4,
    parameter int FLUSH_DEPTH = 1,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int STG_W      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_we,
    input  logic [REG_W-1:0]        issue_rd,
    input  logic [STG_W-1:0]        issue_ready_stage,
    input  logic [REG_W-1:0]        rs1,
    input  logic [REG_W-1:0]        rs2,
    input  logic [XLEN-1:0]         rs1_regfile_data,
    input  logic [XLEN-1:0]         rs2_regfile_data,
    input  logic [STAGES*XLEN-1:0]  stage_result_data,
    input  logic                    ext_stall,
    input  logic                    flush,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic                    rs1_fwd,
    output logic                    rs2_fwd,
    output logic                    stall,
    output logic [NUM_REGS-1:0]     busy_mask,
    output logic [31:0]             hazard_count
);

    // Handshake: the ID instruction moves into EX on an edge where issue_valid=1 and stall=0;
    // a flush drops it instead, and stall=1 holds it in ID for another cycle.
    logic [STAGES-1:0] r_valid;
    logic [REG_W-1:0]  r_rd  [STAGES];
    logic [STG_W-1:0]  r_rdy [STAGES];
    logic [31:0]       r_hazard_count;

    logic              w_rs1_hit, w_rs1_haz, w_rs2_hit, w_rs2_haz;
    logic [XLEN-1:0]   w_rs1_stage, w_rs2_stage;
    logic              w_hazard, w_insert;
    logic [NUM_REGS-1:0] w_busy;

    // Scan from the oldest slot down so the youngest match is the one left standing.
    always_comb begin
        w_rs1_hit   = 1'b0;
        w_rs1_haz   = 1'b0;
        w_rs1_stage = '0;
        w_rs2_hit   = 1'b0;
        w_rs2_haz   = 1'b0;
        w_rs2_stage = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_rd[i] == rs1) && (rs1 != '0)) begin
                w_rs1_hit   = 1'b1;
                w_rs1_haz   = (i < int'(r_rdy[i]));
                w_rs1_stage = stage_result_data[i*XLEN +: XLEN];
            end
            if (r_valid[i] && (r_rd[i] == rs2) && (rs2 != '0)) begin
                w_rs2_hit   = 1'b1;
                w_rs2_haz   = (i < int'(r_rdy[i]));
                w_rs2_stage = stage_result_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (r_valid[i]) begin
                w_busy[r_rd[i]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign w_hazard = (w_rs1_haz | w_rs2_haz) & issue_valid & ~flush;
    assign w_insert = issue_valid & ~w_hazard & ~flush & issue_we & (issue_rd != '0);

    assign rs1_fwd      = w_rs1_hit & ~w_rs1_haz;
    assign rs2_fwd      = w_rs2_hit & ~w_rs2_haz;
    assign rs1_data     = rs1_fwd ? w_rs1_stage : rs1_regfile_data;
    assign rs2_data     = rs2_fwd ? w_rs2_stage : rs2_regfile_data;
    assign stall        = ext_stall | w_hazard;
    assign busy_mask    = w_busy;
    assign hazard_count = r_hazard_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid        <= '0;
            r_hazard_count <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_rd[i]  <= '0;
                r_rdy[i] <= '0;
            end
        end else if (!ext_stall) begin
            // Slots younger than FLUSH_DEPTH after the shift hold wrong-path work.
            for (int i = STAGES - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1] & ~(flush & (i < FLUSH_DEPTH));
                r_rd[i]    <= r_rd[i-1];
                r_rdy[i]   <= r_rdy[i-1];
            end
            r_valid[0] <= w_insert;
            r_rd[0]    <= issue_rd;
            r_rdy[0]   <= issue_ready_stage;
            if (w_hazard && (r_hazard_count != 32'hFFFF_FFFF)) begin
                r_hazard_count <= r_hazard_count + 32'd1;
            end
        end else if (flush) begin
            for (int i = 0; i < FLUSH_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: directed scenarios followed by random traffic,
// all compared against a queue-based model of the in-flight writers.
module tb_pipeline_hazard_scoreboard;
    localparam int XLEN = 32;
    localparam int NR   = 16;
    localparam int ST   = 4;
    localparam int FD   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue_valid, issue_we;
    logic [3:0]         issue_rd;
    logic [1:0]         issue_ready_stage;
    logic [3:0]         rs1, rs2;
    logic [XLEN-1:0]    rs1_regfile_data, rs2_regfile_data;
    logic [ST*XLEN-1:0] stage_result_data;
    logic               ext_stall, flush;
    logic [XLEN-1:0]    rs1_data, rs2_data;
    logic               rs1_fwd, rs2_fwd, stall;
    logic [NR-1:0]      busy_mask;
    logic [31:0]        hazard_count;

    always #5 clk = ~clk;

    pipeline_hazard_scoreboard #(
        .XLEN(XLEN), .NUM_REGS(NR), .STAGES(ST), .FLUSH_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_ready_stage(issue_ready_stage),
        .rs1(rs1), .rs2(rs2),
        .rs1_regfile_data(rs1_regfile_data), .rs2_regfile_data(rs2_regfile_data),
        .stage_result_data(stage_result_data),
        .ext_stall(ext_stall), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .stall(stall), .busy_mask(busy_mask), .hazard_count(hazard_count)
    );

    // Model: pipe[k] is the writer k stages past ID (k=0 is EX).
    typedef struct {
        bit v;
        int rd;
        int rdy;
    } ent_t;

    ent_t        pipe[$];
    int unsigned m_count;
    bit          e_haz;
    int          checks = 0;
    int          errors = 0;
    int unsigned saved_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        ent_t e;
        e.v = 1'b0; e.rd = 0; e.rdy = 0;
        pipe.delete();
        for (int i = 0; i < ST; i++) pipe.push_back(e);
        m_count = 0;
    endtask

    function automatic void lookup(input int rs, output bit hit, output bit haz, output int idx);
        hit = 1'b0; haz = 1'b0; idx = 0;
        if (rs == 0) return;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].v && pipe[i].rd == rs) begin
                hit = 1'b1;
                idx = i;
                haz = (i < pipe[i].rdy);
                return;
            end
        end
    endfunction

    task automatic compare_model();
        bit k1, k2, h1, h2, f1, f2;
        int i1, i2;
        logic [31:0] busy;
        lookup(int'(rs1), k1, h1, i1);
        lookup(int'(rs2), k2, h2, i2);
        e_haz = (h1 | h2) && issue_valid && !flush;
        f1 = k1 && !h1;
        f2 = k2 && !h2;
        check("stall", {31'd0, stall}, {31'd0, ext_stall | e_haz});
        check("rs1_fwd", {31'd0, rs1_fwd}, {31'd0, f1});
        check("rs2_fwd", {31'd0, rs2_fwd}, {31'd0, f2});
        if (!h1) check("rs1_data", rs1_data, f1 ? stage_result_data[i1*XLEN +: XLEN] : rs1_regfile_data);
        if (!h2) check("rs2_data", rs2_data, f2 ? stage_result_data[i2*XLEN +: XLEN] : rs2_regfile_data);
        busy = '0;
        foreach (pipe[i]) if (pipe[i].v) busy[pipe[i].rd] = 1'b1;
        busy[0] = 1'b0;
        check("busy_mask", {16'd0, busy_mask}, busy);
        check("hazard_count", hazard_count, m_count);
    endtask

    task automatic update_model();
        ent_t e;
        if (!ext_stall) begin
            void'(pipe.pop_back());
            e.v   = issue_valid && !e_haz && !flush && issue_we && (issue_rd != 0);
            e.rd  = int'(issue_rd);
            e.rdy = int'(issue_ready_stage);
            pipe.push_front(e);
            if (flush) for (int i = 1; i < FD; i++) pipe[i].v = 1'b0;
            if (e_haz && m_count != 32'hFFFF_FFFF) m_count++;
        end else if (flush) begin
            for (int i = 0; i < FD; i++) pipe[i].v = 1'b0;
        end
    endtask

    task automatic drive(input bit iv, input bit we, input int rd, input int rdy,
                         input int r1, input int r2, input bit ext, input bit fl);
        issue_valid       = iv;
        issue_we          = we;
        issue_rd          = 4'(rd);
        issue_ready_stage = 2'(rdy);
        rs1               = 4'(r1);
        rs2               = 4'(r2);
        ext_stall         = ext;
        flush             = fl;
        rs1_regfile_data  = $urandom;
        rs2_regfile_data  = $urandom;
        for (int s = 0; s < ST; s++) stage_result_data[s*XLEN +: XLEN] = $urandom;
    endtask

    // Compare before the edge, then advance the model with the same inputs.
    task automatic step();
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < ST; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_model();
        #2;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_busy", {16'd0, busy_mask}, 32'd0);
        compare_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back ALU forward from EX
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 5, 0, 0, 0);
        stage_result_data[0 +: XLEN] = 32'hDEAD_BEEF;
        #1;
        check("alu_fwd", {31'd0, rs1_fwd}, 32'd1);
        check("alu_data", rs1_data, 32'hDEAD_BEEF);
        check("alu_stall", {31'd0, stall}, 32'd0);
        step();

        // Load-use: three hazard cycles, then forward from WB
        drive(1, 1, 3, 3, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 3, 0, 0);
            #1;
            check("load_use_stall", {31'd0, stall}, 32'd1);
            step();
        end
        drive(1, 0, 0, 0, 0, 3, 0, 0);
        #1;
        check("load_use_release", {31'd0, stall}, 32'd0);
        check("load_use_fwd", {31'd0, rs2_fwd}, 32'd1);
        check("load_use_data", rs2_data, stage_result_data[3*XLEN +: XLEN]);
        check("load_use_count", hazard_count, 32'd3);
        step();

        // Youngest writer shadows the older one
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 7, 0, 0, 0);
        stage_result_data[1*XLEN +: XLEN] = 32'h11;
        stage_result_data[0*XLEN +: XLEN] = 32'h22;
        #1;
        check("youngest_data", rs1_data, 32'h22);
        step();

        // x0 writer is never tracked
        drain();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("x0_busy", {16'd0, busy_mask}, 32'd0);
        check("x0_fwd", {31'd0, rs1_fwd}, 32'd0);
        step();

        // ext_stall freezes a pending hazard without counting it
        drain();
        drive(1, 1, 9, 3, 0, 0, 0, 0);
        step();
        saved_count = m_count;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 9, 0, 1, 0);
            #1;
            check("ext_stall", {31'd0, stall}, 32'd1);
            check("ext_busy", {16'd0, busy_mask}, 32'h0200);
            check("ext_count", hazard_count, saved_count);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 9, 0, 0, 0);
            step();
        end

        // Flush removes the young writer and drops the issue
        drain();
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 6, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 4, 6, 0, 0);
        #1;
        check("flush_busy", {16'd0, busy_mask}, 32'd0);
        check("flush_fwd", {31'd0, rs1_fwd}, 32'd0);
        step();

        // Asynchronous reset with three writers in flight
        drive(1, 1, 10, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 11, 2, 0, 0, 0, 0);
        step();
        drive(1, 1, 12, 3, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 10, 12, 0, 0);
        rst = 1'b1;
        reset_model();
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_busy", {16'd0, busy_mask}, 32'd0);
        check("midrst_count", hazard_count, 32'd0);
        check("midrst_fwd", {31'd0, rs1_fwd}, 32'd0);
        compare_model();
        #1;
        rst = 1'b0;
        step();

        // Random traffic on a narrow register window to force overlaps
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
Name: pipeline_hazard_scoreboard

Overview:
- Parametrised replacement for the core's fixed forwarding unit and its hand-written stall equation.
- Tracks every in-flight register writer between ID and retirement in a shift-register scoreboard of depth STAGES.
- Each writer declares the stage at which its result becomes forwardable. The block then produces, per cycle, forwarded rs1/rs2 operands or a hazard stall.
- Sits in ID, beside regfile. Serves RV32E (16 registers) or RV32I (32 registers) cores of any post-ID depth.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 16, architectural register count (power of two; x0 hardwired zero).
- STAGES, 4, tracked post-ID stages; index 0 = EX, index STAGES-1 = WB.
- FLUSH_DEPTH, 1, number of youngest stage slots invalidated by flush (1..STAGES).
- Derived: REG_W = $clog2(NUM_REGS); STG_W = max(1, $clog2(STAGES)).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  ID holds a valid instruction that advances if not stalled.
- issue_we  in  1  instruction writes rd.
- issue_rd  in  REG_W  destination register.
- issue_ready_stage  in  STG_W  first stage index at which the result is forwardable (ALU 0, load STAGES-1).
- rs1, rs2  in  REG_W  ID source registers.
- rs1_regfile_data, rs2_regfile_data  in  XLEN  regfile read data.
- stage_result_data  in  STAGES*XLEN  result currently held by each stage; stage i at bits [i*XLEN +: XLEN].
- ext_stall  in  1  memory/SPI/SRAM busy; freezes the whole pipe.
- flush  in  1  branch taken.
- rs1_data, rs2_data  out  XLEN  operand to latch into ID/EX.
- rs1_fwd, rs2_fwd  out  1  operand came from stage_result_data.
- stall  out  1  freeze IF/ID and insert a bubble into EX.
- busy_mask  out  NUM_REGS  registers with a pending write.
- hazard_count  out  32  saturating count of hazard-only stall cycles.

Behaviour:
- State: entry[0..STAGES-1] = {valid, rd, ready_stage}. Only entries with issue_we=1 and rd!=0 are recorded valid.
- Reset (async): all entries invalid and hazard_count=0. Resulting outputs: stall=ext_stall, fwd=0, data=regfile data, busy_mask=0.
- Match, per source rs: take the lowest index i (youngest) with entry[i].valid and entry[i].rd==rs.
  - rs==0: never matches.
  - No match: data=regfile data, fwd=0.
  - Match and i>=entry[i].ready_stage: data=stage_result_data[i], fwd=1.
  - Match and i<entry[i].ready_stage: hazard.
- Older matches are shadowed by the youngest match and never considered.
- The WB-index entry is matched and forwarded, because the regfile write lands at the same edge.
- hazard = (rs1 hazard | rs2 hazard) & issue_valid & ~flush.
- stall = ext_stall | hazard, combinational.
- Clock edge, ext_stall=0:
  - entry[i+1] <= entry[i].
  - entry[STAGES-1] retires.
  - entry[0] <= new instruction if issue_valid & ~hazard & ~flush, else bubble.
- Clock edge, ext_stall=1: all entries hold, no insertion.
- Flush is applied at the same edge:
  - Issue is blocked.
  - Post-update slots 1..FLUSH_DEPTH-1 are forced invalid when ext_stall=0.
  - With ext_stall=1, slots 0..FLUSH_DEPTH-1 are invalidated in place.
  - The branch itself has already moved out of the flushed range and is preserved.
- flush and hazard in the same cycle: flush wins, stall=ext_stall.
- busy_mask[r]=1 iff any valid entry has rd==r; bit 0 is always 0. Combinational from state.
- hazard_count increments on edges where hazard=1 and ext_stall=0. Saturates at 0xFFFFFFFF.
- Latency: forwarding and stall are zero-cycle combinational; the scoreboard updates one edge after issue.

Test Plan:
- Reset mid-operation: 3 valid entries, assert rst between edges -> immediately stall=0, busy_mask=0, hazard_count=0, rs1_fwd=0.
- Back-to-back ALU: issue rd=5, ready 0; next cycle rs1=5, stage_result_data[0]=0xDEADBEEF -> rs1_fwd=1, rs1_data=0xDEADBEEF, stall=0.
- Load-use: issue rd=3, ready 3; next rs2=3 -> stall=1 for 3 cycles, then rs2_data=stage 3 value, stall=0, hazard_count=3.
- Youngest priority: rd=7 issued twice consecutively (stage data 0x11 at index 1, 0x22 at index 0) -> rs1=7 yields 0x22.
- x0 and ext_stall:
  - Issue rd=0, we=1 -> busy_mask=0, no forwarding.
  - ext_stall high 5 cycles with a pending hazard -> entries frozen, stall=1, hazard_count unchanged.
- Flush, FLUSH_DEPTH=2: writer in slot 0 plus flush -> next cycle slot 1 invalid, busy_mask bit cleared, issue dropped.
